// File: rtl/gf2n_pkg.sv
// gf2n_pkg: default field polynomials and share-pair bookkeeping for masked GF(2^N) arithmetic
package gf2n_pkg;
  localparam int POLY_GF4 = 7;
  localparam int POLY_GF16 = 19;
  localparam int POLY_GF256 = 283;
  function automatic int NUM_PAIRS(input int s);
    return s * (s - 1) / 2;
  endfunction
  // row-major index of pair (i,j), i<j: (0,1),(0,2)..(0,s-1),(1,2)...
  function automatic int pairIdx(input int i, input int j, input int s);
    return i * s - i * (i + 1) / 2 + j - i - 1;
  endfunction
endpackage

// File: rtl/gf2n_mul.sv
// gf2n_mul: combinational unmasked GF(2^N) multiplier, carry-less product reduced modulo POLY
module gf2n_mul #(
  parameter int N = 2,
  parameter int POLY = 7
) (
  input  logic [N-1:0] opA,
  input  logic [N-1:0] opB,
  output logic [N-1:0] prod
);
  localparam int W = 2 * N - 1;
  function automatic logic [N-1:0] gfmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) if (b[i]) acc = acc ^ (W'(a) << i);
    for (int i = W - 1; i >= N; i--) if (acc[i]) acc = acc ^ (W'(POLY) << (i - N));
    return acc[N-1:0];
  endfunction
  assign prod = gfmul(opA, opB);
endmodule

// File: rtl/shared_mul_gf2n.sv
// shared_mul_gf2n: DOM-indep masked GF(2^N) multiplier with valid handshake.
// Define SHARED_MUL_OUTREG_EN to register the output shares and valid (latency 2).
module shared_mul_gf2n
  import gf2n_pkg::*;
#(
  parameter int N = 2,
  parameter int POLY = 7,
  parameter int SHARES = 3,
  parameter int PIPELINED = 1
) (
  input  logic                             ClkxCI,
  input  logic                             RstxBI,
  input  logic                             InValidxSI,
  input  logic [N*SHARES-1:0]              _XxDI,
  input  logic [N*SHARES-1:0]              _YxDI,
  input  logic [N*NUM_PAIRS(SHARES)-1:0]   _ZxDI,
  output logic [N*SHARES-1:0]              _QxDO,
  output logic                             OutValidxSO
);
  if (N < 2 || N > 8 || SHARES < 2 || SHARES > 5 || (POLY >> N) != 1) begin : gIllegal
    $error("shared_mul_gf2n: illegal N, POLY or SHARES");
  end
  logic [N*SHARES*SHARES-1:0] terms;
  logic [N*SHARES-1:0] qComb;
  logic validQ;
  for (genvar i = 0; i < SHARES; i++) begin : gRow
    for (genvar j = 0; j < SHARES; j++) begin : gCol
      logic [N-1:0] prod;
      gf2n_mul #(.N(N), .POLY(POLY)) uMul (
        .opA(_XxDI[i*N +: N]),
        .opB(_YxDI[j*N +: N]),
        .prod(prod)
      );
      if (i == j && PIPELINED == 0) begin : gComb
        assign terms[(i*SHARES+j)*N +: N] = prod;
      end else begin : gReg
        logic [N-1:0] mask;
        logic [N-1:0] termQ;
        if (i == j) begin : gInner
          assign mask = '0;
        end else begin : gCross
          // both (i,j) and (j,i) draw the same fresh chunk
          localparam int K = i < j ? pairIdx(i, j, SHARES) : pairIdx(j, i, SHARES);
          assign mask = _ZxDI[K*N +: N];
        end
        always_ff @(posedge ClkxCI or negedge RstxBI)
          if (!RstxBI) termQ <= '0;
          else if (InValidxSI) termQ <= prod ^ mask;
        assign terms[(i*SHARES+j)*N +: N] = termQ;
      end
    end
  end
  always_comb begin
    qComb = '0;
    for (int i = 0; i < SHARES; i++)
      for (int j = 0; j < SHARES; j++)
        qComb[i*N +: N] = qComb[i*N +: N] ^ terms[(i*SHARES+j)*N +: N];
  end
  always_ff @(posedge ClkxCI or negedge RstxBI)
    if (!RstxBI) validQ <= 1'b0;
    else validQ <= InValidxSI;
`ifdef SHARED_MUL_OUTREG_EN
  logic [N*SHARES-1:0] qReg;
  logic validReg;
  always_ff @(posedge ClkxCI or negedge RstxBI)
    if (!RstxBI) begin
      qReg <= '0;
      validReg <= 1'b0;
    end else begin
      validReg <= validQ;
      if (validQ) qReg <= qComb;
    end
  assign _QxDO = qReg;
  assign OutValidxSO = validReg;
`else
  assign _QxDO = qComb;
  assign OutValidxSO = validQ;
`endif
endmodule

// File: tb/tb_shared_mul_gf2n.sv
// tb_shared_mul_gf2n: directed checks of the masked multiplier in GF(4), GF(16) and GF(256)
module tb_shared_mul_gf2n;
  import gf2n_pkg::*;
`ifdef SHARED_MUL_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic vld = 1'b0;
  logic [5:0] x4 = '0, y4 = '0, z4 = '0, q4;
  logic [15:0] x16 = '0, y16 = '0, q16;
  logic [23:0] z16 = '0;
  logic [15:0] x8 = '0, y8 = '0, q8;
  logic [7:0] z8 = '0;
  logic v4, v16, v8;
  int tests = 0;
  int fails = 0;
  logic [1:0] gf4Tab [16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 3, 1, 0, 3, 1, 2};
  int expv [1000];

  always #5 clk = ~clk;

  shared_mul_gf2n #(.N(2), .POLY(POLY_GF4), .SHARES(3), .PIPELINED(1)) dut4 (
    .ClkxCI(clk), .RstxBI(rstN), .InValidxSI(vld),
    ._XxDI(x4), ._YxDI(y4), ._ZxDI(z4), ._QxDO(q4), .OutValidxSO(v4));
  shared_mul_gf2n #(.N(4), .POLY(POLY_GF16), .SHARES(4), .PIPELINED(1)) dut16 (
    .ClkxCI(clk), .RstxBI(rstN), .InValidxSI(vld),
    ._XxDI(x16), ._YxDI(y16), ._ZxDI(z16), ._QxDO(q16), .OutValidxSO(v16));
  shared_mul_gf2n #(.N(8), .POLY(POLY_GF256), .SHARES(2), .PIPELINED(0)) dut256 (
    .ClkxCI(clk), .RstxBI(rstN), .InValidxSI(vld),
    ._XxDI(x8), ._YxDI(y8), ._ZxDI(z8), ._QxDO(q8), .OutValidxSO(v8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // shift-and-add reference multiply
  function automatic int gmul(input int a, input int b, input int n, input int poly);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      if (b[i]) r ^= a;
      a = a << 1;
      if (a[n]) a ^= poly;
    end
    return r;
  endfunction

  function automatic int xs(input logic [63:0] v, input int n, input int s);
    int r = 0;
    for (int i = 0; i < s; i++) r ^= int'((v >> (i * n)) & ((64'd1 << n) - 1));
    return r;
  endfunction

  initial begin
    #2 rstN = 1'b0;
    vld = 1'b1;
    for (int c = 0; c < 2; c++) begin
      x4 = 6'($urandom); y4 = 6'($urandom); z4 = 6'($urandom);
      x16 = 16'($urandom); y16 = 16'($urandom); z16 = 24'($urandom);
      tick();
      check("rst_q4", q4, 0);
      check("rst_v4", v4, 0);
      check("rst_q16", q16, 0);
      check("rst_v16", v16, 0);
      check("rst_v256", v8, 0);
    end
    x4 = 6'h02; y4 = 6'h03; z4 = 6'h00;
    rstN = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check("rel_valid", v4, k == LAT);
    end
    check("rel_prod", xs(q4, 2, 3), 1);

    for (int n = 0; n < 16 + LAT - 1; n++) begin
      vld = n < 16;
      if (n < 16) begin
        x4 = 6'(n / 4); y4 = 6'(n % 4); z4 = '0;
      end
      tick();
      if (n - LAT + 1 >= 0) begin
        check("gf4_valid", v4, 1);
        check("gf4_prod", xs(q4, 2, 3), gf4Tab[n-LAT+1]);
      end
    end

    for (int n = 0; n < 1000 + LAT - 1; n++) begin
      vld = n < 1000;
      if (n == 0) begin
        x16 = 16'h0008; y16 = 16'h0002; expv[0] = 3;
      end else if (n == 1) begin
        x16 = 16'h000F; y16 = 16'h000F; expv[1] = 10;
      end else if (n < 1000) begin
        x16 = 16'($urandom); y16 = 16'($urandom);
        expv[n] = gmul(xs(x16, 4, 4), xs(y16, 4, 4), 4, POLY_GF16);
      end
      z16 = 24'($urandom);
      tick();
      if (n - LAT + 1 >= 0) begin
        check("gf16_valid", v16, 1);
        check("gf16_prod", xs(q16, 4, 4), expv[n-LAT+1]);
      end
    end

    begin
      logic [4:0] pat;
      logic [5:0] qHold;
      pat = 5'b01001;
      qHold = '0;
      vld = 1'b0;
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
        vld = pat[c];
        if (c == 0) begin
          x4 = 6'b01_10_00; y4 = 6'b11_01_01;
        end else if (c == 3) begin
          x4 = 6'b10_01_01; y4 = 6'b00_10_01;
        end else begin
          x4 = 6'($urandom); y4 = 6'($urandom);
        end
        z4 = 6'($urandom);
        tick();
        check("gap_valid", v4, c - LAT + 1 >= 0 ? pat[c-LAT+1] : 1'b0);
        if (c == LAT - 1) begin
          qHold = q4;
          check("gap_first", xs(q4, 2, 3), 2);
        end
        if (c == LAT || c == LAT + 1) check("gap_hold", q4, qHold);
        if (c == LAT + 2) check("gap_second", xs(q4, 2, 3), 1);
      end
    end

    x4 = 6'h03; y4 = 6'h02; z4 = 6'($urandom);
    vld = 1'b1;
    tick();
    vld = 1'b0;
    #2 rstN = 1'b0;
    #1;
    check("midrst_valid", v4, 0);
    check("midrst_q", q4, 0);
    #2 rstN = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      check("midrst_stale_v", v4, 0);
      check("midrst_stale_q", q4, 0);
    end

    for (int n = 0; n < 12; n++) begin
      logic [7:0] m, mb;
      int a, b, e;
      m = 8'($urandom); mb = 8'($urandom);
      if (n == 0) begin
        a = 'h53; b = 'hCA; e = 'h01;
      end else if (n == 1) begin
        a = 'h57; b = 'h83; e = 'hC1;
      end else begin
        a = int'($urandom_range(255)); b = int'($urandom_range(255));
        e = gmul(a, b, 8, POLY_GF256);
      end
      x8 = {m, m ^ 8'(a)};
      y8 = {mb, mb ^ 8'(b)};
      z8 = 8'($urandom);
      vld = 1'b1;
      tick();
      vld = 1'b0;
      for (int k = 1; k < LAT; k++) tick();
      check("gf256_valid", v8, 1);
      check("gf256_prod", xs(q8, 8, 2), e);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shared_mul_gf2n.md
Name: shared_mul_gf2n

Overview:
- DOM-indep masked multiplier over GF(2^N), polynomial basis, generalising the GF(2^2) shared multiplier to any field width N and share count SHARES.
- Adds a valid handshake with register clock-enable and an optional output register stage.
- Building block for the next-generation masked S-box datapath (inversion and exponentiation stages).

Parameters:
- N, 2, field width in bits; legal range 2..8.
- POLY, 7, irreducible reduction polynomial, N+1 bits (bit N is set); 7 = x^2+x+1; 19 (0x13) for N=4.
- SHARES, 3, number of Boolean shares; legal range 2..5.
- PIPELINED, 1, 1 registers inner-domain products; 0 leaves them combinational.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- InValidxSI  in  1  input shares and randomness valid this cycle.
- _XxDI  in  N*SHARES  operand X; share i at [i*N +: N].
- _YxDI  in  N*SHARES  operand Y; same packing as _XxDI.
- _ZxDI  in  N*SHARES*(SHARES-1)/2  fresh randomness; pair k at [k*N +: N].
- _QxDO  out  N*SHARES  product shares; XOR of all shares equals X*Y mod POLY.
- OutValidxSO  out  1  _QxDO holds a valid product.

Behaviour:
- Reset:
  - Asynchronous, active-low: one clock; reset is asynchronous and active-low, ports ClkxCI / RstxBI.
  - RstxBI=0 clears all cross-domain, inner-domain and valid registers to 0 at once: _QxDO=0, OutValidxSO=0.
  - Reset asserted mid-operation drops the in-flight product; no output valid follows.
- Pair enumeration: k runs over pairs (i,j), i<j, row-major: (0,1),(0,2)..(0,S-1),(1,2)...
- Cross-domain term for i≠j: C_ij = gfmul(X_i,Y_j) ^ Z_k(min(i,j),max(i,j)).
  - Each Z chunk is used exactly twice, once for (i,j) and once for (j,i).
  - C_ij is always registered.
- Inner-domain term: I_i = gfmul(X_i,Y_i).
  - Registered when PIPELINED=1.
  - Combinational when PIPELINED=0.
- Output: Q_i = I_i ^ XOR over j≠i of C_ij (registered values). Output XOR is combinational.
- gfmul: carry-less N×N product reduced modulo POLY. Result is exactly N bits, with no extra width.
- Clock enable: all data registers load only when InValidxSI=1 and hold otherwise.
- Valid: OutValidxSO <= InValidxSI each cycle, so latency is 1 cycle and throughput is 1 product per cycle.
- Back-to-back valids:
  - PIPELINED=1: each product appears in consecutive cycles.
  - PIPELINED=0: the source holds X/Y stable for the cycle after InValidxSI. Otherwise the inner and cross terms mix operands; the bench checks this is not done.
- InValidxSI=0: OutValidxSO=0 next cycle. With PIPELINED=1, _QxDO holds its last value.
- SHARES=2 is the minimal case: one Z chunk.
- Illegal N, POLY or SHARES: elaboration-time error via a generate-time check. POLY is illegal when bit N is clear or any bit above N is set.

Optional Feature:
- Macro: SHARED_MUL_OUTREG_EN.
- Defined:
  - Adds a register on each Q_i and on the valid bit, loaded only when the delayed valid is 1.
  - Latency becomes 2 cycles.
  - Output registers reset to 0.
  - Removes the combinational XOR glitch path for downstream leakage robustness.
- Undefined: latency 1; output is the combinational XOR of the registered terms.

Decomposition:
- Package gf2n_pkg:
  - Localparams for default polynomials: POLY_GF4=7, POLY_GF16=19, POLY_GF256=283.
  - Function NUM_PAIRS(S)=S*(S-1)/2.
  - Pair-index function k(i,j).
- Sub-module gf2n_mul: combinational unmasked multiplier with parameters N and POLY. Instantiated SHARES^2 times.

Test Plan:
- Reset check: RstxBI=0 for 2 cycles with random inputs and InValidxSI=1 → _QxDO=0, OutValidxSO=0 throughout; first valid appears 1 cycle after release.
- Exhaustive GF(4): N=2, POLY=7, SHARES=3, all 16 (X,Y) pairs, other shares 0, Z=0, InValidxSI=1 → XOR of shares matches the table, e.g. 2*2=3, 3*3=2, 1*Y=Y.
- Random masking GF(16): N=4, POLY=0x13, SHARES=4, random shares and random Z, 1000 products back-to-back → XOR(Q)=X*Y every cycle, e.g. 0x8*0x2=0x3, 0xF*0xF=0xA.
- Valid gap: InValidxSI pattern 1,0,0,1 → OutValidxSO 0,1,0,0,1; _QxDO is unchanged during the gap (PIPELINED=1).
- Mid-operation reset: RstxBI pulsed low for 0.3 cycle while a valid is in flight → OutValidxSO=0 immediately and no stale product is emitted.
- SHARED_MUL_OUTREG_EN defined, same GF(4) sweep → identical results delayed to latency 2; OutValidxSO aligned with data.
